// File: rtl/bcd_share_arbiter.sv
// Round-robin arbiter that time-shares one 4-bit binary-to-BCD converter among NREQ requesters.
// Optional converter self-check is enabled by defining BCD_ARB_SELFCHECK_EN.
module bcd_share_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] data,
  output logic [3:0]        conv_bin,
  input  logic [4:0]        conv_bcd,
  output logic [4:0]        result,
  output logic [NREQ-1:0]   ack,
  output logic [2:0]        grant_id,
  output logic              busy,
  output logic              error
);

  localparam int unsigned IDW  = 3;
  localparam int unsigned PADW = 8;
  localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [PADW-1:0] req_pad_c;
  logic [IDW-1:0]  idx_c;
  logic [IDW-1:0]  win_c;
  logic            found_c;
  logic [3:0]      op_c;
  logic [3:0]      conv_bin_d;
  logic [4:0]      result_d;
  logic [NREQ-1:0] ack_d;
  logic [IDW-1:0]  grant_id_d;
  logic            busy_d;

  // First requesting index after the last served one, wrapping at NREQ
  always_comb begin
    req_pad_c = PADW'(req);
    idx_c     = '0;
    win_c     = '0;
    found_c   = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx_c = IDW'((32'(last_q) + k) % NREQ);
      if (!found_c && req_pad_c[idx_c]) begin
        found_c = 1'b1;
        win_c   = idx_c;
      end
    end
  end

  // Operand of the winning requester
  always_comb begin
    op_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_c == IDW'(i)) op_c = data[4*i +: 4];
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    conv_bin_d = conv_bin;
    result_d   = result;
    ack_d      = '0;
    grant_id_d = grant_id;
    unique case (state_q)
      IDLE: begin
        if (found_c) begin
          conv_bin_d = op_c;
          grant_id_d = win_c;
          state_d    = CONV;
        end
      end
      CONV: begin
        result_d = conv_bcd;
        ack_d    = NREQ'(1) << grant_id;
        state_d  = DONE;
      end
      DONE: begin
        last_d  = grant_id;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= LAST_RST;
      conv_bin <= '0;
      result   <= '0;
      ack      <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      conv_bin <= conv_bin_d;
      result   <= result_d;
      ack      <= ack_d;
      grant_id <= grant_id_d;
      busy     <= busy_d;
    end
  end

`ifdef BCD_ARB_SELFCHECK_EN
  logic       tens_c;
  logic [4:0] ref_c;

  // Reference conversion of the operand currently on the converter input
  always_comb begin
    tens_c = (conv_bin >= 4'd10);
    ref_c  = tens_c ? {1'b1, conv_bin - 4'd10} : {1'b0, conv_bin};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error <= 1'b0;
    end else if (state_q == CONV && conv_bcd != ref_c) begin
      error <= 1'b1;
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_share_arbiter.sv
// Scoreboard bench for bcd_share_arbiter: directed scenarios followed by random request traffic.
module tb_bcd_share_arbiter;

  localparam int unsigned NREQ = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] data;
  logic [3:0]        conv_bin;
  logic [4:0]        conv_bcd;
  logic [4:0]        result;
  logic [NREQ-1:0]   ack;
  logic [2:0]        grant_id;
  logic              busy;
  logic              error;

  logic [3:0] ops [NREQ];
  logic       corrupt;
  bit         auto_en;
  int         n_checks = 0;
  int         n_fail   = 0;

  typedef struct {
    int         id;
    logic [4:0] res;
  } exp_t;

  exp_t       exp_q[$];
  int         got_ids[$];
  logic [4:0] got_res[$];

  int         m_phase = 0;
  int         m_last  = NREQ - 1;
  int         m_win   = 0;
  logic [3:0] m_op    = '0;
  bit         m_err   = 1'b0;

  always #5 clk = ~clk;

  bcd_share_arbiter #(.NREQ(NREQ)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data     (data),
    .conv_bin (conv_bin),
    .conv_bcd (conv_bcd),
    .result   (result),
    .ack      (ack),
    .grant_id (grant_id),
    .busy     (busy),
    .error    (error)
  );

  function automatic logic [4:0] bcd_of(int v);
    return 5'(((v / 10) * 16) + (v % 10));
  endfunction

  always_comb begin
    for (int i = 0; i < NREQ; i++) data[4*i +: 4] = ops[i];
  end

  // Shared converter; can be made to answer 0 for operand 7
  always_comb conv_bcd = (corrupt && conv_bin == 4'd7) ? 5'd0 : bcd_of(int'(conv_bin));

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int got_id(int j);
    return (j < got_ids.size()) ? got_ids[j] : -1;
  endfunction

  function automatic int got_r(int j);
    return (j < got_res.size()) ? int'(got_res[j]) : -1;
  endfunction

  // Transaction-level reference: one conversion per 3 cycles, rotating priority
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_last  = NREQ - 1;
      m_err   = 1'b0;
      exp_q.delete();
    end else if (m_phase == 0) begin
      if (req != '0) begin
        m_win = -1;
        for (int k = 1; k <= NREQ && m_win < 0; k++) begin
          if (((req >> ((m_last + k) % NREQ)) & 1) != 0) m_win = (m_last + k) % NREQ;
        end
        m_op = ops[m_win];
        exp_q.push_back('{m_win, (corrupt && m_op == 4'd7) ? 5'd0 : bcd_of(int'(m_op))});
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
`ifdef BCD_ARB_SELFCHECK_EN
      if (corrupt && m_op == 4'd7) m_err = 1'b1;
`endif
      m_phase = 2;
    end else begin
      m_last  = m_win;
      m_phase = 0;
    end
  end

  // Monitor: compares every acknowledge and the status outputs each cycle
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (ack != '0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ack: got %0b expected none at %0t", ack, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("ack", 32'(ack), 32'(1 << e.id));
          check("result", 32'(result), 32'(e.res));
          check("grant_id", 32'(grant_id), 32'(e.id));
        end
        for (int i = 0; i < NREQ; i++) begin
          if (ack[i]) got_ids.push_back(i);
        end
        got_res.push_back(result);
      end
      check("ack_present", 32'(ack != '0), 32'(m_phase == 2));
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("error", 32'(error), 32'(m_err));
    end
  end

  // One cycle of requester behaviour: drop after own ack, optional random traffic
  task automatic step();
    @(negedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (ack[i]) begin
        req[i] = 1'b0;
      end else if (auto_en) begin
        if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
        else if (req[i] && $urandom_range(0, 29) == 0) req[i] = 1'b0;
      end
      if (auto_en) ops[i] = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic do_reset(string tag);
    rst = 1'b1;
    #1;
    check({tag, "_rst_ack"}, 32'(ack), 32'd0);
    check({tag, "_rst_busy"}, 32'(busy), 32'd0);
    check({tag, "_rst_result"}, 32'(result), 32'd0);
    check({tag, "_rst_grant_id"}, 32'(grant_id), 32'd0);
    check({tag, "_rst_conv_bin"}, 32'(conv_bin), 32'd0);
    check({tag, "_rst_error"}, 32'(error), 32'd0);
    got_ids.delete();
    got_res.delete();
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic exp_err_set;
    rst     = 1'b1;
    req     = '0;
    corrupt = 1'b0;
    auto_en = 1'b0;
    for (int i = 0; i < NREQ; i++) ops[i] = '0;
    #2;
    do_reset("por");

    // Single request, operand 13
    ops[0] = 4'd13;
    req    = 4'b0001;
    repeat (6) step();
    check("t1_count", 32'(got_ids.size()), 32'd1);
    check("t1_id", 32'(got_id(0)), 32'd0);
    check("t1_res", 32'(got_r(0)), 32'h13);

    // All four requesting at once
    do_reset("t2");
    ops[0] = 4'd2; ops[1] = 4'd10; ops[2] = 4'd15; ops[3] = 4'd9;
    req    = 4'b1111;
    repeat (14) step();
    check("t2_count", 32'(got_ids.size()), 32'd4);
    check("t2_id0", 32'(got_id(0)), 32'd0);
    check("t2_id1", 32'(got_id(1)), 32'd1);
    check("t2_id2", 32'(got_id(2)), 32'd2);
    check("t2_id3", 32'(got_id(3)), 32'd3);
    check("t2_res0", 32'(got_r(0)), 32'h02);
    check("t2_res1", 32'(got_r(1)), 32'h10);
    check("t2_res2", 32'(got_r(2)), 32'h15);
    check("t2_res3", 32'(got_r(3)), 32'h09);

    // Rotation: after requester 0 is served, 2 wins over 0
    do_reset("t3");
    ops[0] = 4'd5;
    req    = 4'b0001;
    repeat (4) step();
    ops[2] = 4'd4;
    req    = 4'b0101;
    repeat (8) step();
    check("t3_count", 32'(got_ids.size()), 32'd3);
    check("t3_id1", 32'(got_id(1)), 32'd2);
    check("t3_id2", 32'(got_id(2)), 32'd0);

    // Requester 1 drops its request during the conversion
    do_reset("t4");
    ops[1] = 4'd12;
    req    = 4'b0010;
    step();
    req[1] = 1'b0;
    repeat (4) step();
    check("t4_count", 32'(got_ids.size()), 32'd1);
    check("t4_id", 32'(got_id(0)), 32'd1);
    check("t4_res", 32'(got_r(0)), 32'h12);

    // Reset while converting, then re-arbitrate from requester 0
    do_reset("t5");
    ops[1] = 4'd11; ops[2] = 4'd3;
    req    = 4'b0110;
    step();
    check("t5_busy_before", 32'(busy), 32'd1);
    do_reset("t5mid");
    repeat (8) step();
    check("t5_count", 32'(got_ids.size()), 32'd2);
    check("t5_id0", 32'(got_id(0)), 32'd1);
    check("t5_id1", 32'(got_id(1)), 32'd2);
    check("t5_res0", 32'(got_r(0)), 32'h11);

    // Faulty converter answer for operand 7
`ifdef BCD_ARB_SELFCHECK_EN
    exp_err_set = 1'b1;
`else
    exp_err_set = 1'b0;
`endif
    do_reset("t6");
    corrupt = 1'b1;
    ops[0]  = 4'd7;
    req     = 4'b0001;
    repeat (5) step();
    check("t6_error_set", 32'(error), 32'(exp_err_set));
    check("t6_res", 32'(got_r(0)), 32'h00);
    corrupt = 1'b0;
    ops[0]  = 4'd3;
    req     = 4'b0001;
    repeat (5) step();
    check("t6_error_sticky", 32'(error), 32'(exp_err_set));
    do_reset("t6end");

    // Random traffic with operands changing every cycle
    auto_en = 1'b1;
    repeat (900) step();
    auto_en = 1'b0;
    req     = '0;
    repeat (6) step();
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    check("random_idle_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
